// File: rtl/sys_array_feeder.sv
// Diagonal skew feeder for the systolic mesh: row m and column c lanes delayed m+1 / c+1 cycles.
// Optional: SYS_FEEDER_ZERO_BUBBLE_EN forces data lanes to zero on bubble beats.
module sys_array_feeder #(
    parameter int MESHROWS    = 2,
    parameter int MESHCOLUMNS = 2,
    parameter int TILEROWS    = 1,
    parameter int TILECOLUMNS = 1,
    parameter int BITWIDTH    = 8,
    parameter int BLOCK_GAP   = 1
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic                                              in_last,
    input  logic [MESHROWS-1:0][TILEROWS-1:0][BITWIDTH-1:0]   in_a,
    input  logic [MESHCOLUMNS-1:0][TILECOLUMNS-1:0][BITWIDTH-1:0] in_b,
    input  logic [MESHCOLUMNS-1:0][TILECOLUMNS-1:0][BITWIDTH-1:0] in_d,
    input  logic                                              in_dataflow,
    output logic [MESHROWS-1:0][TILEROWS-1:0][BITWIDTH-1:0]   out_a,
    output logic [MESHCOLUMNS-1:0][TILECOLUMNS-1:0][BITWIDTH-1:0] out_b,
    output logic [MESHCOLUMNS-1:0][TILECOLUMNS-1:0][BITWIDTH-1:0] out_d,
    output logic [MESHCOLUMNS-1:0][TILECOLUMNS-1:0]           out_dataflow,
    output logic [MESHCOLUMNS-1:0][TILECOLUMNS-1:0]           out_propagate,
    output logic [MESHCOLUMNS-1:0][TILECOLUMNS-1:0]           out_valid,
    output logic                                              block_done,
    output logic                                              busy
);

    localparam int D  = (MESHROWS > MESHCOLUMNS) ? MESHROWS : MESHCOLUMNS;
    localparam int GW = (BLOCK_GAP > 1) ? $clog2(BLOCK_GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_GAP} state_t;

    state_t          r_state;
    logic [GW-1:0]   r_gap_cnt;
    logic            r_ready;
    logic            r_p;
    logic [D-1:0]    r_tv;
    logic [D-1:0]    r_tl;
    logic            w_xfer;

    assign w_xfer     = in_valid && r_ready;
    assign in_ready   = r_ready;
    assign busy       = (r_state != S_IDLE) || (|r_tv);
    assign block_done = r_tv[D-1] & r_tl[D-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
            r_ready   <= 1'b0;
            r_p       <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            if (w_xfer && in_last)
                r_p <= ~r_p;
            case (r_state)
                S_IDLE, S_FEED: begin
                    if (w_xfer) begin
                        if (!in_last) begin
                            r_state <= S_FEED;
                        end else if (BLOCK_GAP > 0) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= GW'(BLOCK_GAP - 1);
                            r_ready   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GW'(1);
                        r_ready   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tracks beats through the deepest lane for busy and block_done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tv <= '0;
            r_tl <= '0;
        end else begin
            r_tv <= (r_tv << 1) | D'(w_xfer);
            r_tl <= (r_tl << 1) | D'(w_xfer && in_last);
        end
    end

    for (genvar m = 0; m < MESHROWS; m++) begin : g_row
        logic [TILEROWS-1:0][BITWIDTH-1:0] r_a [m+1];

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                for (int k = 0; k <= m; k++) r_a[k] <= '0;
            end else begin
`ifdef SYS_FEEDER_ZERO_BUBBLE_EN
                r_a[0] <= w_xfer ? in_a[m] : '0;
`else
                if (w_xfer) r_a[0] <= in_a[m];
`endif
                for (int k = 1; k <= m; k++) r_a[k] <= r_a[k-1];
            end
        end

        assign out_a[m] = r_a[m];
    end

    for (genvar c = 0; c < MESHCOLUMNS; c++) begin : g_col
        logic [TILECOLUMNS-1:0][BITWIDTH-1:0] r_b [c+1];
        logic [TILECOLUMNS-1:0][BITWIDTH-1:0] r_d [c+1];
        logic                                 r_df [c+1];
        logic                                 r_pr [c+1];
        logic                                 r_v  [c+1];

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                for (int k = 0; k <= c; k++) begin
                    r_b[k]  <= '0;
                    r_d[k]  <= '0;
                    r_df[k] <= 1'b0;
                    r_pr[k] <= 1'b0;
                    r_v[k]  <= 1'b0;
                end
            end else begin
`ifdef SYS_FEEDER_ZERO_BUBBLE_EN
                r_b[0] <= w_xfer ? in_b[c] : '0;
                r_d[0] <= w_xfer ? in_d[c] : '0;
`else
                if (w_xfer) begin
                    r_b[0] <= in_b[c];
                    r_d[0] <= in_d[c];
                end
`endif
                // Control lanes follow the live values even on bubbles.
                r_df[0] <= in_dataflow;
                r_pr[0] <= r_p;
                r_v[0]  <= w_xfer;
                for (int k = 1; k <= c; k++) begin
                    r_b[k]  <= r_b[k-1];
                    r_d[k]  <= r_d[k-1];
                    r_df[k] <= r_df[k-1];
                    r_pr[k] <= r_pr[k-1];
                    r_v[k]  <= r_v[k-1];
                end
            end
        end

        assign out_b[c]         = r_b[c];
        assign out_d[c]         = r_d[c];
        assign out_dataflow[c]  = {TILECOLUMNS{r_df[c]}};
        assign out_propagate[c] = {TILECOLUMNS{r_pr[c]}};
        assign out_valid[c]     = {TILECOLUMNS{r_v[c]}};
    end

endmodule

// File: tb/tb_sys_array_feeder.sv
// Random-stimulus bench for sys_array_feeder: one instance with BLOCK_GAP=1, one with BLOCK_GAP=0.
// Each is checked against a cycle-level delay/queue model kept here.
module tb_sys_array_feeder;

    typedef logic [1:0][0:0][7:0] vec_t;
    typedef struct packed {
        logic v;
        logic l;
        logic p;
        logic df;
        vec_t a;
        vec_t b;
        vec_t d;
    } rec_t;

    localparam int NCYC    = 400;
    localparam int RST_CYC = 200;

    logic clock;
    logic reset;

    logic            tb_v[2], tb_l[2], tb_df[2];
    vec_t            tb_a[2], tb_b[2], tb_d[2];
    logic            o_rdy[2], o_done[2], o_busy[2];
    vec_t            o_a[2], o_b[2], o_d[2];
    logic [1:0][0:0] o_df[2], o_pr[2], o_vl[2];

    int   n_chk  = 0;
    int   n_pass = 0;

    int   m_gap[2];
    logic m_p[2], m_started[2], m_inblk[2];
    rec_t hist[2][2];

    sys_array_feeder #(
        .MESHROWS(2), .MESHCOLUMNS(2), .TILEROWS(1), .TILECOLUMNS(1),
        .BITWIDTH(8), .BLOCK_GAP(1)
    ) u_dut_g1 (
        .clock(clock), .reset(reset),
        .in_valid(tb_v[0]), .in_ready(o_rdy[0]), .in_last(tb_l[0]),
        .in_a(tb_a[0]), .in_b(tb_b[0]), .in_d(tb_d[0]), .in_dataflow(tb_df[0]),
        .out_a(o_a[0]), .out_b(o_b[0]), .out_d(o_d[0]),
        .out_dataflow(o_df[0]), .out_propagate(o_pr[0]), .out_valid(o_vl[0]),
        .block_done(o_done[0]), .busy(o_busy[0])
    );

    sys_array_feeder #(
        .MESHROWS(2), .MESHCOLUMNS(2), .TILEROWS(1), .TILECOLUMNS(1),
        .BITWIDTH(8), .BLOCK_GAP(0)
    ) u_dut_g0 (
        .clock(clock), .reset(reset),
        .in_valid(tb_v[1]), .in_ready(o_rdy[1]), .in_last(tb_l[1]),
        .in_a(tb_a[1]), .in_b(tb_b[1]), .in_d(tb_d[1]), .in_dataflow(tb_df[1]),
        .out_a(o_a[1]), .out_b(o_b[1]), .out_d(o_d[1]),
        .out_dataflow(o_df[1]), .out_propagate(o_pr[1]), .out_valid(o_vl[1]),
        .block_done(o_done[1]), .busy(o_busy[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset(input int i);
        m_gap[i]     = 0;
        m_p[i]       = 1'b0;
        m_started[i] = 1'b0;
        m_inblk[i]   = 1'b0;
        hist[i][0]   = '0;
        hist[i][1]   = '0;
    endtask

    task automatic model_step(input int i);
        rec_t r;
        logic x;
        x    = tb_v[i] && m_started[i] && (m_gap[i] == 0);
        r.v  = x;
        r.l  = x && tb_l[i];
        r.p  = m_p[i];
        r.df = tb_df[i];
        r.a  = tb_a[i];
        r.b  = tb_b[i];
        r.d  = tb_d[i];
        hist[i][1] = hist[i][0];
        hist[i][0] = r;
        if (m_gap[i] > 0) m_gap[i]--;
        if (x) begin
            if (tb_l[i]) begin
                m_p[i]     = ~m_p[i];
                m_gap[i]   = gap_of(i);
                m_inblk[i] = 1'b0;
            end else begin
                m_inblk[i] = 1'b1;
            end
        end
        m_started[i] = 1'b1;
    endtask

    task automatic check_ready(input int i);
        chk($sformatf("g%0d in_ready", gap_of(i)), 64'(o_rdy[i]),
            64'(m_started[i] && (m_gap[i] == 0)));
    endtask

    task automatic check_out(input int i);
        logic bexp;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("g%0d valid[%0d]", gap_of(i), k),
                64'(o_vl[i][k]), 64'(hist[i][k].v));
            chk($sformatf("g%0d propagate[%0d]", gap_of(i), k),
                64'(o_pr[i][k]), 64'(hist[i][k].p));
            chk($sformatf("g%0d dataflow[%0d]", gap_of(i), k),
                64'(o_df[i][k]), 64'(hist[i][k].df));
            if (hist[i][k].v) begin
                chk($sformatf("g%0d a[%0d]", gap_of(i), k),
                    64'(o_a[i][k]), 64'(hist[i][k].a[k]));
                chk($sformatf("g%0d b[%0d]", gap_of(i), k),
                    64'(o_b[i][k]), 64'(hist[i][k].b[k]));
                chk($sformatf("g%0d d[%0d]", gap_of(i), k),
                    64'(o_d[i][k]), 64'(hist[i][k].d[k]));
            end
`ifdef SYS_FEEDER_ZERO_BUBBLE_EN
            else begin
                chk($sformatf("g%0d bubble a[%0d]", gap_of(i), k),
                    64'(o_a[i][k]), 64'(0));
                chk($sformatf("g%0d bubble b[%0d]", gap_of(i), k),
                    64'(o_b[i][k]), 64'(0));
            end
`endif
        end
        chk($sformatf("g%0d block_done", gap_of(i)),
            64'(o_done[i]), 64'(hist[i][1].l));
        bexp = m_inblk[i] || (m_gap[i] > 0) || hist[i][0].v || hist[i][1].v;
        chk($sformatf("g%0d busy", gap_of(i)), 64'(o_busy[i]), 64'(bexp));
    endtask

    task automatic check_reset_state(input int i);
        chk($sformatf("g%0d rst in_ready", gap_of(i)), 64'(o_rdy[i]), 64'(0));
        chk($sformatf("g%0d rst out_a", gap_of(i)), 64'(o_a[i]), 64'(0));
        chk($sformatf("g%0d rst out_b", gap_of(i)), 64'(o_b[i]), 64'(0));
        chk($sformatf("g%0d rst out_d", gap_of(i)), 64'(o_d[i]), 64'(0));
        chk($sformatf("g%0d rst valid", gap_of(i)), 64'(o_vl[i]), 64'(0));
        chk($sformatf("g%0d rst propagate", gap_of(i)), 64'(o_pr[i]), 64'(0));
        chk($sformatf("g%0d rst dataflow", gap_of(i)), 64'(o_df[i]), 64'(0));
        chk($sformatf("g%0d rst block_done", gap_of(i)), 64'(o_done[i]), 64'(0));
        chk($sformatf("g%0d rst busy", gap_of(i)), 64'(o_busy[i]), 64'(0));
    endtask

    task automatic drive(input int i, input int cyc);
        tb_v[i]  = ($urandom_range(0, 3) != 0);
        tb_l[i]  = ($urandom_range(0, 2) == 0);
        tb_df[i] = 1'($urandom);
        tb_a[i]  = 16'($urandom);
        tb_b[i]  = 16'($urandom);
        tb_d[i]  = 16'($urandom);
        if (cyc == 0) tb_v[i] = 1'b0;
        if (i == 0 && cyc == 1) begin
            tb_v[i]    = 1'b1;
            tb_l[i]    = 1'b1;
            tb_a[i][0] = 8'd3;
            tb_a[i][1] = 8'hFB;
            tb_b[i][0] = 8'd7;
            tb_b[i][1] = 8'd9;
        end
        if (i == 1 && cyc >= 1 && cyc <= 4) begin
            tb_v[i] = 1'b1;
            tb_l[i] = 1'b1;
        end
        // Two-cycle bubble window for both instances.
        if (cyc == 6 || cyc == 7) tb_v[i] = 1'b0;
        if (cyc == RST_CYC - 2 || cyc == RST_CYC - 1) begin
            tb_v[i] = 1'b1;
            tb_l[i] = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tb_v[i] = 1'b0; tb_l[i] = 1'b0; tb_df[i] = 1'b0;
            tb_a[i] = '0;   tb_b[i] = '0;   tb_d[i] = '0;
            model_reset(i);
        end
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_state(0);
        check_reset_state(1);
        reset = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc == RST_CYC) begin
                tb_v[0] = 1'b0;
                tb_v[1] = 1'b0;
                #2 reset = 1'b0;
                #1;
                check_reset_state(0);
                check_reset_state(1);
                @(posedge clock);
                @(negedge clock);
                reset = 1'b1;
                model_reset(0);
                model_reset(1);
                continue;
            end
            drive(0, cyc);
            drive(1, cyc);
            check_ready(0);
            check_ready(1);
            @(posedge clock);
            model_step(0);
            model_step(1);
            @(negedge clock);
            check_out(0);
            check_out(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
